// File: rtl/parser_defs.sv
// Shared parser definitions.
// Holds the parsed message record handed from the parser FIFOs to the order
// book, the message-type and order-side encodings, the state type of the
// book feed arbiter FSM, and a helper that says which message types the
// order book accepts.
package parser_defs;

    // Message type encodings (ASCII letters as they appear on the wire)
    localparam logic [7:0] MSG_ADD    = 8'h41;
    localparam logic [7:0] MSG_UPDATE = 8'h55;
    localparam logic [7:0] MSG_DELETE = 8'h44;

    // Order side encodings
    localparam logic ORDER_SIDE_BID = 1'b0;
    localparam logic ORDER_SIDE_ASK = 1'b1;

    // One parsed message as read out of a parser FIFO
    typedef struct packed {
        logic [7:0]  msg_type;
        logic        side;
        logic [63:0] order_id;
        logic [31:0] price;
        logic [31:0] qty;
    } parsed_msg_t;

    // Book feed arbiter FSM states
    typedef enum logic [2:0] {
        FA_IDLE    = 3'd0,
        FA_FETCH   = 3'd1,
        FA_CAPTURE = 3'd2,
        FA_ISSUE   = 3'd3,
        FA_SETTLE  = 3'd4
    } feed_arb_state_t;

    // True for the message types the order book knows how to apply
    function automatic logic is_book_msg(input logic [7:0] msg_type);
        return (msg_type == MSG_ADD) || (msg_type == MSG_UPDATE) ||
               (msg_type == MSG_DELETE);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request searching upward from last_grant+1,
// wrapping modulo NUM_REQ, so the most recently granted requester has the
// lowest priority.
// Ports:
//   req         - request vector, one bit per requester
//   last_grant  - index of the previous grant
//   grant       - index of the chosen requester (0 when nothing requests)
//   grant_valid - high when at least one request is asserted
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       grant_valid
);

    localparam int GW = $clog2(NUM_REQ);

    // Walk the offsets from farthest to nearest so that the nearest
    // requester after last_grant overwrites any earlier candidate.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[GW'(idx)]) begin
                grant       = GW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/book_feed_arbiter.sv
// Book feed arbiter.
// Round-robins over the parser output FIFOs, pops one message at a time,
// registers it and strobes it into the order book, then waits a settle
// window so the book's best bid/ask outputs update before the next message.
// Messages of a type the book does not accept are counted and dropped.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   src_empty     - per-source FIFO empty flags
//   src_rd_en     - per-source pop strobe (at most one bit high)
//   src_msg       - per-source FIFO read data, valid the cycle after a pop
//   book_read_en  - one-cycle message strobe to the order book
//   book_empty    - inverse of book_read_en
//   book_msg      - registered message presented to the order book
//   grant_src     - most recently granted source index
//   busy          - high whenever the FSM is not idle
//   msg_count     - messages issued to the book (wraps)
//   drop_count    - messages dropped for an illegal type (saturates)
module book_feed_arbiter
    import parser_defs::*;
#(
    parameter int NUM_SRC       = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         src_empty,
    output logic [NUM_SRC-1:0]         src_rd_en,
    input  parsed_msg_t                src_msg [NUM_SRC],
    output logic                       book_read_en,
    output logic                       book_empty,
    output parsed_msg_t                book_msg,
    output logic [$clog2(NUM_SRC)-1:0] grant_src,
    output logic                       busy,
    output logic [31:0]                msg_count,
    output logic [15:0]                drop_count
);

    localparam int GW = $clog2(NUM_SRC);
    localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    feed_arb_state_t state;
    feed_arb_state_t next_state;
    logic [GW-1:0]   arb_grant;
    logic            arb_valid;
    logic [SW-1:0]   settle_cnt;

    rr_arbiter #(
        .NUM_REQ(NUM_SRC)
    ) u_rr_arbiter (
        .req        (~src_empty),
        .last_grant (grant_src),
        .grant      (arb_grant),
        .grant_valid(arb_valid)
    );

    // Next-state logic: a fixed FETCH/CAPTURE/ISSUE walk per message, then
    // SETTLE_CYCLES cycles of settle before looking at the FIFOs again.
    always_comb begin
        next_state = state;
        case (state)
            FA_IDLE:    if (arb_valid) next_state = FA_FETCH;
            FA_FETCH:   next_state = FA_CAPTURE;
            FA_CAPTURE: next_state = FA_ISSUE;
            FA_ISSUE:   next_state = FA_SETTLE;
            FA_SETTLE:  if (settle_cnt == SETTLE_LAST) next_state = FA_IDLE;
            default:    next_state = FA_IDLE;
        endcase
    end

    // State, grant pointer, message register and counters. The grant is
    // latched on leaving IDLE and doubles as the index used in FETCH and
    // CAPTURE. A reset during FETCH/CAPTURE discards the popped message.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FA_IDLE;
            grant_src  <= GW'(NUM_SRC - 1);
            book_msg   <= '0;
            busy       <= 1'b0;
            msg_count  <= '0;
            drop_count <= '0;
            settle_cnt <= '0;
        end else begin
            state <= next_state;
            busy  <= (next_state != FA_IDLE);
            if (state == FA_IDLE && arb_valid) begin
                grant_src <= arb_grant;
            end
            if (state == FA_CAPTURE) begin
                book_msg <= src_msg[grant_src];
            end
            if (state == FA_ISSUE) begin
                if (is_book_msg(book_msg.msg_type)) begin
                    msg_count <= msg_count + 32'd1;
                end else if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
            settle_cnt <= (state == FA_SETTLE) ? settle_cnt + SW'(1) : '0;
        end
    end

    // Strobes decoded from the state register and the registered message.
    always_comb begin
        src_rd_en = '0;
        if (state == FA_FETCH) begin
            src_rd_en[grant_src] = 1'b1;
        end
    end

    assign book_read_en = (state == FA_ISSUE) && is_book_msg(book_msg.msg_type);
    assign book_empty   = !book_read_en;

endmodule

// File: tb/tb_book_feed_arbiter.sv
// Testbench for book_feed_arbiter.
// Models each source FIFO as a queue, pushes the expected book message and
// granted source into a scoreboard whenever a legal message is loaded, and
// a monitor pops and compares on every book_read_en strobe.
module tb_book_feed_arbiter;
    import parser_defs::*;

    localparam int NUM_SRC       = 2;
    localparam int SETTLE_CYCLES = 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       src_empty;
    logic [1:0]       src_rd_en;
    parsed_msg_t      src_msg [NUM_SRC];
    logic             book_read_en;
    logic             book_empty;
    parsed_msg_t      book_msg;
    logic [0:0]       grant_src;
    logic             busy;
    logic [31:0]      msg_count;
    logic [15:0]      drop_count;

    typedef struct {
        parsed_msg_t msg;
        int          src;
    } exp_t;

    exp_t        expQ[$];
    parsed_msg_t fifoQ[NUM_SRC][$];
    int          strobeCycles[$];
    int          popCycles[$];
    logic [1:0]  popMasks[$];
    int          strobeCount = 0;
    int          assertCount = 0;
    int          failCount   = 0;
    int          cycle       = 0;
    exp_t        monExp;

    book_feed_arbiter #(
        .NUM_SRC(NUM_SRC),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .src_empty   (src_empty),
        .src_rd_en   (src_rd_en),
        .src_msg     (src_msg),
        .book_read_en(book_read_en),
        .book_empty  (book_empty),
        .book_msg    (book_msg),
        .grant_src   (grant_src),
        .busy        (busy),
        .msg_count   (msg_count),
        .drop_count  (drop_count)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Loads one message into a source FIFO; legal messages also go into
    // the scoreboard in the order the bench expects them to be granted
    task automatic applyStimulus(input int src, input logic [7:0] mtype,
                                 input logic side, input logic [63:0] id,
                                 input logic [31:0] price, input logic [31:0] qty,
                                 input bit expectIssue);
        parsed_msg_t m;
        m.msg_type = mtype;
        m.side     = side;
        m.order_id = id;
        m.price    = price;
        m.qty      = qty;
        fifoQ[src].push_back(m);
        if (expectIssue) expQ.push_back('{msg: m, src: src});
    endtask

    // Holds reset for three cycles and releases it away from the clock edge
    task automatic doReset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Waits, with a cycle budget, until all FIFOs are drained and the DUT is idle
    task automatic waitDrained(input int maxCycles);
        int n = 0;
        while ((busy || src_empty != 2'b11 || fifoQ[0].size() != 0 ||
                fifoQ[1].size() != 0) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("drain_timeout", 64'(n < maxCycles), 64'd1);
    endtask

    // FIFO model: pops on src_rd_en, read data holds until the next pop
    initial begin
        src_empty = 2'b11;
        for (int i = 0; i < NUM_SRC; i++) src_msg[i] = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_SRC; i++) begin
                if (src_rd_en[i]) begin
                    if (fifoQ[i].size() > 0) src_msg[i] = fifoQ[i].pop_front();
                    else checkOutput("pop_from_empty", 64'd1, 64'd0);
                end
                src_empty[i] = (fifoQ[i].size() == 0);
            end
        end
    end

    // Monitor: records pops and strobes and compares each strobe against
    // the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                checkOutput("book_empty", 64'(book_empty), 64'(!book_read_en));
                if (src_rd_en != 2'b00) begin
                    popCycles.push_back(cycle);
                    popMasks.push_back(src_rd_en);
                    checkOutput("rd_onehot", 64'($onehot(src_rd_en)), 64'd1);
                end
                if (book_read_en) begin
                    strobeCycles.push_back(cycle);
                    strobeCount++;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_strobe", 64'd1, 64'd0);
                    end else begin
                        monExp = expQ.pop_front();
                        checkOutput("msg_type", 64'(book_msg.msg_type), 64'(monExp.msg.msg_type));
                        checkOutput("side",     64'(book_msg.side),     64'(monExp.msg.side));
                        checkOutput("order_id", book_msg.order_id,      monExp.msg.order_id);
                        checkOutput("price",    64'(book_msg.price),    64'(monExp.msg.price));
                        checkOutput("qty",      64'(book_msg.qty),      64'(monExp.msg.qty));
                        checkOutput("grant_src", 64'(grant_src),        64'(monExp.src));
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int base;
        int n;
        logic [1:0] expMask;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values and idling with all FIFOs empty
        @(negedge clk);
        checkOutput("rst_busy",       64'(busy),         64'd0);
        checkOutput("rst_grant_src",  64'(grant_src),    64'd1);
        checkOutput("rst_msg_count",  64'(msg_count),    64'd0);
        checkOutput("rst_drop_count", 64'(drop_count),   64'd0);
        checkOutput("rst_read_en",    64'(book_read_en), 64'd0);
        checkOutput("rst_book_msg",   64'(book_msg[63:0]), 64'd0);
        checkOutput("rst_src_rd_en",  64'(src_rd_en),    64'd0);
        repeat (20) @(negedge clk);
        checkOutput("idle_busy",    64'(busy),              64'd0);
        checkOutput("idle_strobes", 64'(strobeCount),       64'd0);
        checkOutput("idle_pops",    64'(popCycles.size()),  64'd0);
        checkOutput("idle_msg_cnt", 64'(msg_count),         64'd0);

        // Single ADD on source 0: pop then strobe two cycles later
        @(posedge clk); #1;
        applyStimulus(0, MSG_ADD, ORDER_SIDE_BID, 64'd1001, 32'd100, 32'd10, 1'b1);
        waitDrained(40);
        checkOutput("single_pops",   64'(popCycles.size()), 64'd1);
        checkOutput("single_mask",   64'(popMasks[0]),      64'h1);
        checkOutput("single_strobe", 64'(strobeCount),      64'd1);
        checkOutput("single_latency", 64'(strobeCycles[0] - popCycles[0]), 64'd2);
        checkOutput("single_msg_cnt", 64'(msg_count),       64'd1);
        checkOutput("single_price",  64'(book_msg.price),   64'd100);

        // Three messages on each source after reset: alternating grants
        doReset();
        @(negedge clk);
        checkOutput("rr_rst_msg_cnt", 64'(msg_count), 64'd0);
        base = popMasks.size();
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, MSG_ADD,    ORDER_SIDE_BID, 64'(2000 + k), 32'(101 + k), 32'(5 + k), 1'b1);
            applyStimulus(1, MSG_UPDATE, ORDER_SIDE_ASK, 64'(3000 + k), 32'(200 + k), 32'(7 + k), 1'b1);
        end
        waitDrained(80);
        checkOutput("rr_pops", 64'(popMasks.size() - base), 64'd6);
        for (int k = 0; k < 6; k++) begin
            expMask = (k % 2 == 0) ? 2'b01 : 2'b10;
            if (base + k < popMasks.size())
                checkOutput("rr_order", 64'(popMasks[base + k]), 64'(expMask));
        end
        n = strobeCycles.size();
        checkOutput("rr_strobes", 64'(strobeCount), 64'd7);
        for (int k = n - 5; k < n; k++) begin
            if (k > 0) checkOutput("rr_spacing", 64'(strobeCycles[k] - strobeCycles[k - 1]), 64'd5);
        end
        checkOutput("rr_msg_cnt", 64'(msg_count), 64'd6);

        // Illegal type on source 1: popped, not issued, counted as a drop
        base = popMasks.size();
        @(posedge clk); #1;
        applyStimulus(1, 8'h58, ORDER_SIDE_BID, 64'd4000, 32'd300, 32'd1, 1'b0);
        waitDrained(40);
        checkOutput("drop_pops",    64'(popMasks.size() - base), 64'd1);
        if (popMasks.size() > base) checkOutput("drop_mask", 64'(popMasks[base]), 64'h2);
        checkOutput("drop_strobes", 64'(strobeCount), 64'd7);
        checkOutput("drop_count",   64'(drop_count),  64'd1);
        checkOutput("drop_msg_cnt", 64'(msg_count),   64'd6);

        // Saturation: drop counter preset to its maximum must stay there
        @(posedge clk); #1;
        force dut.drop_count = 16'hFFFF;
        @(posedge clk); #1;
        release dut.drop_count;
        @(negedge clk);
        checkOutput("sat_preset", 64'(drop_count), 64'hFFFF);
        @(posedge clk); #1;
        applyStimulus(0, 8'h00, ORDER_SIDE_ASK, 64'd5000, 32'd1, 32'd1, 1'b0);
        waitDrained(40);
        checkOutput("sat_drop_count", 64'(drop_count), 64'hFFFF);
        checkOutput("sat_msg_cnt",    64'(msg_count),  64'd6);

        // Reset during CAPTURE: popped message discarded, reset values return
        @(posedge clk); #1;
        applyStimulus(0, MSG_ADD, ORDER_SIDE_BID, 64'd6000, 32'd150, 32'd3, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (src_rd_en == 2'b00 && n < 20);
        checkOutput("cap_fetch_timeout", 64'(n < 20), 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("cap_busy",       64'(busy),            64'd0);
        checkOutput("cap_grant_src",  64'(grant_src),       64'd1);
        checkOutput("cap_msg_count",  64'(msg_count),       64'd0);
        checkOutput("cap_drop_count", 64'(drop_count),      64'd0);
        checkOutput("cap_book_msg",   64'(book_msg[63:0]),  64'd0);
        repeat (10) @(negedge clk);
        checkOutput("cap_no_strobe",  64'(strobeCount),     64'd7);
        checkOutput("cap_idle_busy",  64'(busy),            64'd0);

        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/book_feed_arbiter.md
# book_feed_arbiter

Sequencer that feeds the order book from several parsed-message FIFOs. Round-robin picks a non-empty source FIFO, pops one message, and presents it to the order book as a single-cycle `read_en` pulse. It then holds off for a settle window so the book's best-bid/ask outputs update before the next message. The block sits between the parser output FIFOs (for example, primary and recovery feeds) and `order_book`, and is the sole reader of every source FIFO.

## Interface
- `NUM_SRC`, default 2: number of source FIFOs; must be at least 2.
- `SETTLE_CYCLES`, default 1: idle cycles after each issue; must be at least 1.
- `clk` input, 1 bit: single clock.
- `reset` input, 1 bit: synchronous, active-high.
- `src_empty` input, `NUM_SRC` bits: per-source FIFO empty flag.
- `src_rd_en` output, `NUM_SRC` bits: per-source pop pulse.
- `src_msg` input, `NUM_SRC` × `parsed_msg_t`: FIFO read data, valid the cycle after `src_rd_en`.
- `book_read_en` output, 1 bit: one-cycle message strobe to the order book.
- `book_empty` output, 1 bit: always equal to `!book_read_en`.
- `book_msg` output, `parsed_msg_t`: registered message to the book.
- `grant_src` output, `$clog2(NUM_SRC)` bits: index of the most recently granted source.
- `busy` output, 1 bit: high whenever the FSM is not in IDLE.
- `msg_count` output, 32 bits: messages issued to the book; wraps.
- `drop_count` output, 16 bits: messages dropped for an illegal `msg_type`; saturates at 0xFFFF.

## Operation
- FSM states: IDLE, FETCH, CAPTURE, ISSUE, SETTLE.
- IDLE:
  - If any `src_empty` bit is 0, latch the grant `g` and go to FETCH.
  - `g` is the first non-empty index searched from `grant_src+1` upward, wrapping modulo `NUM_SRC`.
  - Otherwise stay in IDLE.
- FETCH: `src_rd_en[g]`=1 for exactly one cycle; go to CAPTURE.
- CAPTURE: register `src_msg[g]` into `book_msg`; go to ISSUE.
- ISSUE, when `book_msg.msg_type` is MSG_ADD, MSG_UPDATE or MSG_DELETE:
  - `book_read_en`=1 for one cycle.
  - `msg_count` increments by 1.
- ISSUE, for any other `msg_type`:
  - `book_read_en` stays 0.
  - `drop_count` increments unless it is already 0xFFFF.
- ISSUE always goes to SETTLE.
- SETTLE: count `SETTLE_CYCLES` cycles, then return to IDLE.
- `grant_src` updates to `g` on the IDLE→FETCH transition.
- All outputs other than the strobes are registered. `src_rd_en` and `book_read_en` are Moore-decoded from the state register.
- At most one `src_rd_en` bit is high in any cycle.

## Timing
- Reset values:
  - State IDLE; `src_rd_en`=0; `book_read_en`=0; `book_empty`=1; `book_msg`=0.
  - `grant_src`=`NUM_SRC-1`, so source 0 wins first after reset.
  - `busy`=0; `msg_count`=0; `drop_count`=0.
- Latency: a non-empty source sampled in IDLE at cycle t gives FETCH at t+1, CAPTURE at t+2, ISSUE at t+3, SETTLE from t+4, and IDLE at t+4+`SETTLE_CYCLES`.
- Throughput: one message per 4+`SETTLE_CYCLES` cycles. With the defaults this is 1 per 5 cycles.
- Fairness: when all sources stay non-empty, grants rotate 0,1,…,`NUM_SRC-1`,0. No source waits more than `NUM_SRC`-1 other grants.
- A source's empty flag cannot reassert between grant and pop, because this block is its only reader. The grant therefore never produces an unneeded pop.
- Reset asserted in any state, including mid-FETCH or mid-CAPTURE:
  - Next cycle is IDLE with reset values.
  - A message already popped but not yet issued is discarded and not counted.
- Reset wins over every other event in the same cycle.
- `msg_count` wraps from 0xFFFFFFFF to 0.
- `drop_count` holds at 0xFFFF.

## Structure
- `parsed_msg_t`, the MSG_* encodings and the ORDER_SIDE_* encodings remain in the shared `parser_defs.sv`.
- Add the FSM state enum `feed_arb_state_t` to the same file.
- Sub-module `rr_arbiter`:
  - Purely combinational.
  - Inputs: request vector (`~src_empty`) and last-grant pointer.
  - Outputs: grant index and grant-valid.
- The FSM, counters and `book_msg` register live in `book_feed_arbiter`.

## Test plan
- Reset, then hold `src_empty`=2'b11 for 20 cycles → `busy`=0, no strobes, both counters 0.
- Source 0 holds one ADD (bid, price 100, qty 10) → `src_rd_en`=2'b01 at t+1; `book_read_en` at t+3 with that `book_msg`; `msg_count`=1; the order book then shows `best_bid_price`=100.
- Both sources hold 3 messages each → grant order 0,1,0,1,0,1 with 5 cycles between `book_read_en` pulses; `msg_count`=6.
- Source 1 holds a message with an illegal `msg_type` → `src_rd_en[1]` pulses, no `book_read_en`, `drop_count`=1, `msg_count` unchanged.
- Assert `reset` during CAPTURE → IDLE next cycle; the popped message is never issued; `grant_src`=1 (`NUM_SRC-1`); counters 0.
- Force `drop_count` to 0xFFFF, then drop another message → `drop_count` stays 0xFFFF.
